// File: rtl/riscv_test_monitor_pkg.sv
// Shared types for the riscv-tests pass/fail monitor.
// State and verdict encodings plus default register indices.
package riscv_test_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        V_NONE,
        V_PASS,
        V_FAIL,
        V_TIMEOUT
    } verdict_e;

    localparam int DEF_DONE_REG   = 26;
    localparam int DEF_RESULT_REG = 27;

    // Width that holds SETTLE_CYCLES-1 (at least one bit).
    function automatic int settle_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_test_monitor_timer.sv
// Settle down-counter and saturating armed-cycle up-counter,
// each with a terminal-count flag.
module riscv_test_monitor_timer #(
    parameter int CNT_W          = 32,
    parameter int DN_W           = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             up_en,
    input  logic             dn_load,
    input  logic             dn_en,
    input  logic [DN_W-1:0]  dn_init,
    output logic [CNT_W-1:0] up_cnt,
    output logic             dn_zero,
    output logic             up_tc
);

    localparam logic [CNT_W-1:0] UP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [DN_W-1:0] dn_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_cnt <= '0;
            dn_cnt <= '0;
        end else if (clr) begin
            up_cnt <= '0;
            dn_cnt <= '0;
        end else begin
            if (up_en && !(&up_cnt))
                up_cnt <= up_cnt + 1'b1;
            if (dn_load)
                dn_cnt <= dn_init;
            else if (dn_en && dn_cnt != '0)
                dn_cnt <= dn_cnt - 1'b1;
        end
    end

    assign dn_zero = (dn_cnt == '0);
    assign up_tc   = (TIMEOUT_CYCLES != 0) && (up_cnt == UP_LAST);

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests: snoops register-file writes,
// waits a settle window after the done write, then latches a verdict.
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              DONE_REG       = DEF_DONE_REG,
    parameter int              RESULT_REG     = DEF_RESULT_REG,
    parameter logic [XLEN-1:0] PASS_VALUE     = XLEN'(1),
    parameter int              SETTLE_CYCLES  = 2,
    parameter int              TIMEOUT_CYCLES = 100000,
    parameter int              CNT_W          = 32,
    parameter bit              AUTO_START     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  result_value,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int SW = settle_w(SETTLE_CYCLES);

    state_e          state;
    verdict_e        verdict;
    logic            boot;
    logic            armed;
    logic            arm;
    logic            done_hit;
    logic            res_hit;
    logic            settle_exp;
    logic            to_exp;
    logic            finish;
    logic            dn_zero;
    logic            up_tc;
    logic [XLEN-1:0] res_next;

    assign armed = (state == ST_RUN) || (state == ST_SETTLE);
    assign arm   = start || boot;

    // x0 is hardwired zero in the core, so its writes never count.
    assign res_hit = armed && wr_en && wr_addr != 5'd0
                   && wr_addr == 5'(RESULT_REG);
    assign done_hit = (state == ST_RUN) && wr_en && wr_addr != 5'd0
                    && wr_addr == 5'(DONE_REG) && (|wr_data);

    assign res_next   = res_hit ? wr_data : result_value;
    assign settle_exp = (state == ST_SETTLE) && dn_zero;
    assign to_exp     = armed && up_tc;
    assign finish     = settle_exp || to_exp;

    riscv_test_monitor_timer #(
        .CNT_W          (CNT_W),
        .DN_W           (SW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (arm),
        .up_en   (armed && !finish),
        .dn_load (done_hit),
        .dn_en   (state == ST_SETTLE),
        .dn_init (SW'(SETTLE_CYCLES - 1)),
        .up_cnt  (cycle_count),
        .dn_zero (dn_zero),
        .up_tc   (up_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            verdict      <= V_NONE;
            boot         <= AUTO_START;
            result_value <= '0;
        end else begin
            boot <= 1'b0;
            if (arm) begin
                state        <= ST_RUN;
                verdict      <= V_NONE;
                result_value <= '0;
            end else begin
                if (res_hit)
                    result_value <= wr_data;
                unique case (state)
                    ST_RUN: begin
                        if (to_exp) begin
                            state   <= ST_DONE;
                            verdict <= V_TIMEOUT;
                        end else if (done_hit) begin
                            state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        // Settle expiry outranks a coincident timeout.
                        if (settle_exp) begin
                            state   <= ST_DONE;
                            verdict <= (res_next == PASS_VALUE)
                                     ? V_PASS : V_FAIL;
                        end else if (to_exp) begin
                            state   <= ST_DONE;
                            verdict <= V_TIMEOUT;
                        end
                    end
                    ST_IDLE, ST_DONE: ;
                endcase
            end
        end
    end

    assign busy    = armed;
    assign done    = (verdict != V_NONE);
    assign pass    = (verdict == V_PASS);
    assign fail    = (verdict == V_FAIL);
    assign timeout = (verdict == V_TIMEOUT);

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor with a deadline-based reference
// model compared every cycle, plus hand-computed spot checks.
module tb_riscv_test_monitor;

    localparam int SETTLE  = 2;
    localparam int TO      = 50;
    localparam int DREG    = 26;
    localparam int RREG    = 27;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] result_value;
    logic [31:0] cycle_count;

    int checks = 0;
    int failures = 0;

    riscv_test_monitor #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .result_value (result_value),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    // Reference model: verdict 0 none, 1 pass, 2 fail, 3 timeout.
    // A done write schedules the verdict at a fixed armed-cycle deadline.
    bit          m_boot, m_armed;
    int          m_cnt, m_due, m_v;
    logic [31:0] m_res, m_r;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_boot = 1; m_armed = 0; m_cnt = 0;
            m_due = -1; m_res = 0; m_v = 0;
        end else if (start || m_boot) begin
            m_boot = 0; m_armed = 1; m_cnt = 0;
            m_due = -1; m_res = 0; m_v = 0;
        end else if (m_armed) begin
            m_r = m_res;
            if (wr_en && wr_addr == RREG)
                m_r = wr_data;
            if (m_due < 0 && wr_en && wr_addr == DREG && wr_data != 0)
                m_due = m_cnt + SETTLE;
            if (m_due == m_cnt) begin
                m_armed = 0;
                m_v = (m_r == 32'd1) ? 1 : 2;
            end else if (m_cnt == TO - 1) begin
                m_armed = 0;
                m_v = 3;
            end else begin
                m_cnt++;
            end
            m_res = m_r;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", {63'd0, busy}, {63'd0, m_armed});
        chk("done", {63'd0, done}, {63'd0, m_v != 0});
        chk("pass", {63'd0, pass}, {63'd0, m_v == 1});
        chk("fail", {63'd0, fail}, {63'd0, m_v == 2});
        chk("timeout", {63'd0, timeout}, {63'd0, m_v == 3});
        chk("result", {32'd0, result_value}, {32'd0, m_res});
        chk("count", {32'd0, cycle_count}, 64'(m_cnt));
    end

    // Drive one cycle of inputs, return at the next falling edge.
    task automatic cyc(input logic en, input logic [4:0] a,
                       input logic [31:0] d, input logic st);
        wr_en = en; wr_addr = a; wr_data = d; start = st;
        @(negedge clk);
        wr_en = 0; wr_addr = '0; wr_data = '0; start = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0);
    endtask

    task automatic flags(input string name, input logic [4:0] exp);
        chk(name, {59'd0, busy, done, pass, fail, timeout},
            {59'd0, exp});
    endtask

    initial begin
        #1;
        flags("rst_flags", 5'b00000);
        chk("rst_count", {32'd0, cycle_count}, 64'd0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        flags("boot_busy", 5'b10000);
        chk("boot_count", {32'd0, cycle_count}, 64'd0);

        // Pass run
        cyc(1, 5'd27, 32'd1, 0);
        cyc(1, 5'd26, 32'd1, 0);
        idle(3);
        flags("pass_flags", 5'b01100);
        chk("pass_res", {32'd0, result_value}, 64'd1);
        chk("pass_count", {32'd0, cycle_count}, 64'd3);
        idle(4);
        chk("pass_frozen", {32'd0, cycle_count}, 64'd3);

        // Restart from DONE, then late result with x0 noise
        cyc(0, 5'd0, 32'd0, 1);
        flags("rs_done", 5'b10000);
        chk("rs_done_res", {32'd0, result_value}, 64'd0);
        cyc(1, 5'd0, 32'd1, 0);
        chk("x0_ignored", {32'd0, result_value}, 64'd0);
        cyc(1, 5'd26, 32'd1, 0);
        idle(1);
        cyc(1, 5'd27, 32'd5, 0);
        flags("late_flags", 5'b01010);
        chk("late_res", {32'd0, result_value}, 64'd5);
        chk("late_count", {32'd0, cycle_count}, 64'd3);

        // Restart mid-SETTLE with a discarded result write
        cyc(0, 5'd0, 32'd0, 1);
        cyc(1, 5'd26, 32'd1, 0);
        cyc(1, 5'd27, 32'd9, 1);
        flags("rs_settle", 5'b10000);
        chk("rs_settle_res", {32'd0, result_value}, 64'd0);
        chk("rs_settle_cnt", {32'd0, cycle_count}, 64'd0);
        cyc(1, 5'd27, 32'd1, 0);
        cyc(1, 5'd26, 32'd7, 0);
        idle(3);
        flags("run2_flags", 5'b01100);

        // Timeout
        cyc(0, 5'd0, 32'd0, 1);
        idle(49);
        flags("to_edge", 5'b10000);
        chk("to_edge_cnt", {32'd0, cycle_count}, 64'd49);
        idle(1);
        flags("to_flags", 5'b01001);
        chk("to_count", {32'd0, cycle_count}, 64'd49);
        cyc(1, 5'd26, 32'd1, 0);
        idle(2);
        flags("to_after", 5'b01001);

        // Settle expiry coincides with timeout; zero x26 write ignored
        cyc(0, 5'd0, 32'd0, 1);
        cyc(1, 5'd27, 32'd1, 0);
        idle(9);
        cyc(1, 5'd26, 32'd0, 0);
        idle(36);
        chk("co_pre_cnt", {32'd0, cycle_count}, 64'd47);
        flags("co_zero_done", 5'b10000);
        cyc(1, 5'd26, 32'd1, 0);
        idle(2);
        flags("co_flags", 5'b01100);
        chk("co_count", {32'd0, cycle_count}, 64'd49);

        // Async reset in the middle of SETTLE
        cyc(0, 5'd0, 32'd0, 1);
        cyc(1, 5'd27, 32'd3, 0);
        cyc(1, 5'd26, 32'd1, 0);
        #2 rst = 0;
        #1;
        flags("arst_flags", 5'b00000);
        chk("arst_res", {32'd0, result_value}, 64'd0);
        chk("arst_cnt", {32'd0, cycle_count}, 64'd0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        flags("rearm_busy", 5'b10000);
        chk("rearm_cnt0", {32'd0, cycle_count}, 64'd0);
        idle(1);
        chk("rearm_cnt1", {32'd0, cycle_count}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
